time_display_scan: RTL

Downstream display stage for the calendar/clock counter block. Takes its six 8-bit binary fields (year, month, day, hour, minute, second) and drives a six-digit multiplexed 7-segment display. It snapshots one page of three fields per scan frame and converts each field to two BCD digits with a sequential subtract-by-10 engine. Decoded segments are driven one digit at a time.

---
 rtl/time_display_scan.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment driver for the calendar/clock block: snapshots one page of three
// binary fields per scan frame, converts each to two BCD digits by repeated subtraction, then scans.
module time_display_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] year,
    input  logic [7:0] month,
    input  logic [7:0] day,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic       page_sel,
    output logic [7:0] seg,
    output logic [5:0] dig,
    output logic       frame
);

    localparam int            CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    CODE_DASH  = 4'hA;
    localparam logic [3:0]    CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick, rst_seen, frame_start;
    logic [7:0]    work [3];
    logic [1:0]    fld;
    logic [7:0]    rem;
    logic [3:0]    tens;
    logic          over, field_done;
    logic [23:0]   conv_vec, disp_vec, src_vec;
    logic [3:0]    cur_code;

    function automatic logic [6:0] seg_of(input logic [3:0] code);
        case (code)
            4'd0:      seg_of = 7'b1000000;
            4'd1:      seg_of = 7'b1111001;
            4'd2:      seg_of = 7'b0100100;
            4'd3:      seg_of = 7'b0110000;
            4'd4:      seg_of = 7'b0011001;
            4'd5:      seg_of = 7'b0010010;
            4'd6:      seg_of = 7'b0000010;
            4'd7:      seg_of = 7'b1111000;
            4'd8:      seg_of = 7'b0000000;
            4'd9:      seg_of = 7'b0010000;
            CODE_DASH: seg_of = 7'b0111111;
            default:   seg_of = 7'b1111111;
        endcase
    endfunction

    assign tick        = (cnt == CNT_MAX);
    assign frame_start = rst_seen || (tick && idx == 3'd5);
    assign over        = (work[0] >= 8'd100);
    assign field_done  = over || (rem < 8'd10);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            rst_seen <= 1'b1;
            state    <= IDLE;
        end else begin
            rst_seen <= 1'b0;
            state    <= state_nxt;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        frame     = 1'b0;
        case (state)
            IDLE:    if (frame_start) state_nxt = CONV;
            CONV:    if (field_done && fld == 2'd2) state_nxt = COMMIT;
            COMMIT: begin
                frame     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: working registers are always reloaded by a snapshot before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (frame_start) begin
            work[0] <= page_sel ? year  : hour;
            work[1] <= page_sel ? month : minute;
            work[2] <= page_sel ? day   : second;
            rem     <= page_sel ? year  : hour;
            tens    <= '0;
            fld     <= '0;
        end else if (state == CONV) begin
            if (field_done) begin
                // Fields shift left so the first converted pair ends up in digits 5,4.
                conv_vec <= {conv_vec[15:0], over ? {CODE_DASH, CODE_DASH} : {tens, rem[3:0]}};
                work[0]  <= work[1];
                work[1]  <= work[2];
                rem      <= work[1];
                tens     <= '0;
                fld      <= fld + 2'd1;
            end else begin
                rem  <= rem - 8'd10;
                tens <= tens + 4'd1;
            end
        end
    end

    // During COMMIT the freshly converted digits bypass the display registers so seg updates next cycle.
    always_comb begin
        src_vec  = (state == COMMIT) ? conv_vec : disp_vec;
        cur_code = CODE_BLANK;
        case (idx)
            3'd0:    cur_code = src_vec[3:0];
            3'd1:    cur_code = src_vec[7:4];
            3'd2:    cur_code = src_vec[11:8];
            3'd3:    cur_code = src_vec[15:12];
            3'd4:    cur_code = src_vec[19:16];
            3'd5:    cur_code = src_vec[23:20];
            default: cur_code = CODE_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_vec <= {6{CODE_BLANK}};
            seg      <= 8'hFF;
            dig      <= 6'b111110;
        end else begin
            if (state == COMMIT) disp_vec <= conv_vec;
            seg <= {~((idx == 3'd4 || idx == 3'd2) && cur_code != CODE_BLANK), seg_of(cur_code)};
            dig <= ~(6'b000001 << idx);
        end
    end

endmodule
